// File: rtl/alu_frame_parser_if.sv
// Stream-side bundle of the frame parser: UART byte input, echo byte output,
// ALU operand word output and the error pulse.
interface alu_frame_parser_if;
    logic        valid_i;
    logic [7:0]  data_i;
    logic        ready_o;
    logic        echo_valid_o;
    logic [7:0]  echo_data_o;
    logic        echo_ready_i;
    logic        op_valid_o;
    logic [31:0] op_data_o;
    logic [1:0]  op_code_o;
    logic        op_first_o;
    logic        op_last_o;
    logic        op_ready_i;
    logic        err_o;
    logic [1:0]  err_code_o;

    modport master (
        input  valid_i, data_i, echo_ready_i, op_ready_i,
        output ready_o, echo_valid_o, echo_data_o, op_valid_o, op_data_o,
               op_code_o, op_first_o, op_last_o, err_o, err_code_o
    );

    modport slave (
        output valid_i, data_i, echo_ready_i, op_ready_i,
        input  ready_o, echo_valid_o, echo_data_o, op_valid_o, op_data_o,
               op_code_o, op_first_o, op_last_o, err_o, err_code_o
    );
endinterface

// File: rtl/alu_frame_parser.sv
// Header-decoding byte parser: forwards echo payload, packs arithmetic payload
// into little-endian 32-bit operand words, drains and flags malformed packets.
module alu_frame_parser #(
    parameter int unsigned TimeoutCycles = 0
) (
    input logic                clk_i,
    input logic                reset_i,
    alu_frame_parser_if.master bus
);
    typedef enum logic [2:0] {OPC, RSVD, LEN_LO, LEN_HI, ECHO, OPND, DROP} state_t;

    state_t      state, state_nxt;
    logic [7:0]  opc, len_lo;
    logic [15:0] rem, len, rem_hdr;
    logic [31:0] cnt;
    logic [1:0]  idx, pkt_code, code_q, hdr_err;
    logic [23:0] partial;
    logic        first_word, ready, acc, timeout, opc_arith;

    logic        echo_valid, op_valid, op_first, op_last, err;
    logic [7:0]  echo_data;
    logic [31:0] op_data;
    logic [1:0]  op_code, err_code;

    assign bus.ready_o      = ready;
    assign bus.echo_valid_o = echo_valid;
    assign bus.echo_data_o  = echo_data;
    assign bus.op_valid_o   = op_valid;
    assign bus.op_data_o    = op_data;
    assign bus.op_code_o    = op_code;
    assign bus.op_first_o   = op_first;
    assign bus.op_last_o    = op_last;
    assign bus.err_o        = err;
    assign bus.err_code_o   = err_code;

    always_ff @(posedge clk_i) begin
        if (reset_i) state <= OPC;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        timeout   = 1'b0;
        hdr_err   = 2'd0;
        pkt_code  = 2'd0;
        opc_arith = 1'b1;
        len       = {bus.data_i, len_lo};
        rem_hdr   = len - 16'd4;
        case (opc)
            8'hAD:   pkt_code = 2'd0;
            8'h88:   pkt_code = 2'd1;
            8'h89:   pkt_code = 2'd2;
            default: opc_arith = 1'b0;
        endcase
        case (state)
            ECHO:    ready = !echo_valid || bus.echo_ready_i;
            OPND:    ready = !op_valid || bus.op_ready_i;
            default: ready = 1'b1;
        endcase
        if (reset_i) ready = 1'b0;
        acc = bus.valid_i && ready;
        if (acc) begin
            case (state)
                OPC:    state_nxt = RSVD;
                RSVD:   state_nxt = LEN_LO;
                LEN_LO: state_nxt = LEN_HI;
                LEN_HI: begin
                    if (len < 16'd4) begin
                        hdr_err   = 2'd2;
                        state_nxt = OPC;
                    end else if (opc == 8'hEC) begin
                        state_nxt = (rem_hdr == 16'd0) ? OPC : ECHO;
                    end else if (opc_arith && rem_hdr[1:0] == 2'd0 && rem_hdr >= 16'd8) begin
                        state_nxt = OPND;
                    end else begin
                        hdr_err   = opc_arith ? 2'd2 : 2'd1;
                        state_nxt = (rem_hdr != 16'd0) ? DROP : OPC;
                    end
                end
                // ECHO, OPND and DROP all finish on the byte that empties rem
                default: if (rem == 16'd1) state_nxt = OPC;
            endcase
        end
        if (TimeoutCycles != 0 && state != OPC && !acc && cnt + 32'd1 == 32'(TimeoutCycles)) begin
            timeout   = 1'b1;
            state_nxt = OPC;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            opc        <= 8'd0;
            len_lo     <= 8'd0;
            rem        <= 16'd0;
            cnt        <= 32'd0;
            idx        <= 2'd0;
            partial    <= 24'd0;
            first_word <= 1'b0;
            code_q     <= 2'd0;
            echo_valid <= 1'b0;
            echo_data  <= 8'd0;
            op_valid   <= 1'b0;
            op_data    <= 32'd0;
            op_code    <= 2'd0;
            op_first   <= 1'b0;
            op_last    <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'd0;
        end else begin
            err      <= 1'b0;
            err_code <= 2'd0;
            if (echo_valid && bus.echo_ready_i) echo_valid <= 1'b0;
            if (op_valid && bus.op_ready_i)     op_valid   <= 1'b0;
            cnt <= (state == OPC || acc) ? 32'd0 : cnt + 32'd1;
            if (acc) begin
                case (state)
                    OPC:    opc    <= bus.data_i;
                    LEN_LO: len_lo <= bus.data_i;
                    LEN_HI: begin
                        rem        <= rem_hdr;
                        idx        <= 2'd0;
                        first_word <= 1'b1;
                        code_q     <= pkt_code;
                        if (hdr_err != 2'd0) begin
                            err      <= 1'b1;
                            err_code <= hdr_err;
                        end
                    end
                    ECHO: begin
                        echo_data  <= bus.data_i;
                        echo_valid <= 1'b1;
                        rem        <= rem - 16'd1;
                    end
                    OPND: begin
                        rem <= rem - 16'd1;
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            op_data    <= {bus.data_i, partial};
                            op_valid   <= 1'b1;
                            op_code    <= code_q;
                            op_first   <= first_word;
                            op_last    <= (rem == 16'd1);
                            first_word <= 1'b0;
                        end else begin
                            partial[{idx, 3'b000} +: 8] <= bus.data_i;
                        end
                    end
                    DROP:    rem <= rem - 16'd1;
                    default: ;
                endcase
            end
            // registered outputs already in flight stay put on abort
            if (timeout) begin
                err      <= 1'b1;
                err_code <= 2'd3;
                idx      <= 2'd0;
                partial  <= 24'd0;
            end
        end
    end
endmodule

// File: tb/tb_alu_frame_parser.sv
// Directed and randomized checks of alu_frame_parser against a packet-level
// reference model of the byte protocol.
module tb_alu_frame_parser;
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  code;
        logic        first;
        logic        last;
    } op_t;

    logic clk_i = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk_i = ~clk_i;

    alu_frame_parser_if bus();
    alu_frame_parser #(.TimeoutCycles(100)) dut (.clk_i(clk_i), .reset_i(reset_i), .bus(bus));

    int total = 0;
    int bad = 0;
    int stray = 0;
    int mode = 0;  // 0: readies high, 1: random readies, 2: op_ready held low

    logic [7:0] stim[$];
    logic [7:0] exp_echo[$];
    op_t        exp_op[$];
    logic [1:0] exp_err[$];
    logic [7:0] got_echo[$];
    op_t        got_op[$];
    logic [1:0] got_err[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: walks whole packets using the length field, no cycle detail.
    task automatic model();
        int i, len, rem, nw;
        logic [7:0] opc;
        op_t w;
        i = 0;
        while (i + 4 <= stim.size()) begin
            opc = stim[i];
            len = int'(stim[i+2]) + 256 * int'(stim[i+3]);
            i += 4;
            if (len < 4) begin
                exp_err.push_back(2'd2);
                continue;
            end
            rem = len - 4;
            if (opc == 8'hEC) begin
                for (int k = 0; k < rem; k++) exp_echo.push_back(stim[i+k]);
            end else if (opc inside {8'hAD, 8'h88, 8'h89}) begin
                if (rem % 4 == 0 && rem >= 8) begin
                    nw = rem / 4;
                    for (int k = 0; k < nw; k++) begin
                        w.data  = {stim[i+4*k+3], stim[i+4*k+2], stim[i+4*k+1], stim[i+4*k]};
                        w.code  = (opc == 8'hAD) ? 2'd0 : (opc == 8'h88) ? 2'd1 : 2'd2;
                        w.first = (k == 0);
                        w.last  = (k == nw - 1);
                        exp_op.push_back(w);
                    end
                end else begin
                    exp_err.push_back(2'd2);
                end
            end else begin
                exp_err.push_back(2'd1);
            end
            i += rem;
        end
    endtask

    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (bus.echo_valid_o && bus.echo_ready_i) got_echo.push_back(bus.echo_data_o);
            if (bus.op_valid_o && bus.op_ready_i)
                got_op.push_back({bus.op_data_o, bus.op_code_o, bus.op_first_o, bus.op_last_o});
            if (bus.err_o) got_err.push_back(bus.err_code_o);
            if (!bus.err_o && bus.err_code_o != 2'd0) stray++;
        end
    end

    initial begin
        bus.echo_ready_i = 1'b1;
        bus.op_ready_i   = 1'b1;
        forever begin
            @(posedge clk_i); #1;
            case (mode)
                0:       begin bus.echo_ready_i = 1'b1; bus.op_ready_i = 1'b1; end
                1:       begin
                    bus.echo_ready_i = ($urandom_range(0, 3) != 0);
                    bus.op_ready_i   = ($urandom_range(0, 3) != 0);
                end
                default: begin bus.echo_ready_i = 1'b1; bus.op_ready_i = 1'b0; end
            endcase
        end
    end

    task automatic clear_q();
        stim.delete(); exp_echo.delete(); exp_op.delete(); exp_err.delete();
        got_echo.delete(); got_op.delete(); got_err.delete();
        stray = 0;
    endtask

    // Returns at posedge+1 right after the byte has been accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.valid_i = 1'b1;
        bus.data_i  = b;
        forever begin
            @(negedge clk_i);
            if (bus.ready_o || n >= 300) break;
            n++;
        end
        check("accept_wait", {63'd0, bus.ready_o}, 64'd1);
        @(posedge clk_i); #1;
        bus.valid_i = 1'b0;
    endtask

    task automatic send_stream(input int gap);
        int k;
        for (int i = 0; i < stim.size(); i++) begin
            send_byte(stim[i]);
            k = $urandom_range(0, gap);
            repeat (k) begin @(posedge clk_i); #1; end
        end
    endtask

    task automatic drain_compare(input string tag);
        int n;
        n = 0;
        repeat (3) @(negedge clk_i);
        while ((bus.echo_valid_o || bus.op_valid_o) && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "/drained"}, {62'd0, bus.echo_valid_o, bus.op_valid_o}, 64'd0);
        check({tag, "/echo_n"}, got_echo.size(), exp_echo.size());
        for (int k = 0; k < got_echo.size() && k < exp_echo.size(); k++)
            check($sformatf("%s/echo%0d", tag, k), got_echo[k], exp_echo[k]);
        check({tag, "/op_n"}, got_op.size(), exp_op.size());
        for (int k = 0; k < got_op.size() && k < exp_op.size(); k++)
            check($sformatf("%s/op%0d", tag, k), got_op[k], exp_op[k]);
        check({tag, "/err_n"}, got_err.size(), exp_err.size());
        for (int k = 0; k < got_err.size() && k < exp_err.size(); k++)
            check($sformatf("%s/err%0d", tag, k), got_err[k], exp_err[k]);
        check({tag, "/err_code_idle"}, stray, 0);
        clear_q();
        @(posedge clk_i); #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "/echo_valid"}, bus.echo_valid_o, 0);
        check({tag, "/echo_data"}, bus.echo_data_o, 0);
        check({tag, "/op_valid"}, bus.op_valid_o, 0);
        check({tag, "/op_data"}, bus.op_data_o, 0);
        check({tag, "/op_code"}, bus.op_code_o, 0);
        check({tag, "/op_flags"}, {bus.op_first_o, bus.op_last_o}, 0);
        check({tag, "/err"}, {bus.err_o, bus.err_code_o}, 0);
        check({tag, "/ready"}, bus.ready_o, 0);
    endtask

    task automatic gen_pkt();
        int kind, len, sel;
        logic [7:0] opc;
        logic [7:0] arith[3];
        arith = '{8'hAD, 8'h88, 8'h89};
        kind = int'($urandom_range(0, 4));
        sel  = int'($urandom_range(0, 2));
        case (kind)
            0:       begin opc = 8'hEC;      len = 4 + int'($urandom_range(0, 6)); end
            1:       begin opc = arith[sel]; len = 4 + 4 * int'($urandom_range(2, 4)); end
            2:       begin opc = arith[sel]; len = 4 + int'($urandom_range(0, 7)); end
            3:       begin opc = 8'h10 + 8'($urandom_range(0, 15)); len = 4 + int'($urandom_range(0, 5)); end
            default: begin opc = arith[sel]; len = int'($urandom_range(0, 3)); end
        endcase
        stim.push_back(opc);
        stim.push_back(8'($urandom));
        stim.push_back(8'(len));
        stim.push_back(8'(len >> 8));
        for (int k = 4; k < len; k++) stim.push_back(8'($urandom));
    endtask

    initial begin
        int e;
        time t0;
        logic [31:0] held;
        bus.valid_i = 1'b0;
        bus.data_i  = 8'd0;

        // reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_outputs_zero("reset");
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        @(negedge clk_i);
        check("ready_after_reset", bus.ready_o, 1);
        @(posedge clk_i); #1;

        // echo with one-cycle latency
        mode = 0;
        stim = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42};
        model();
        for (int i = 0; i < stim.size(); i++) begin
            send_byte(stim[i]);
            if (i >= 4) check($sformatf("echo_lat%0d", i),
                              {bus.echo_valid_o, bus.echo_data_o}, {1'b1, stim[i]});
        end
        drain_compare("echo");

        // add packet: full throughput and operand latency
        stim = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                 8'h02, 8'h00, 8'h00, 8'h00};
        model();
        t0 = $time;
        for (int i = 0; i < stim.size(); i++) begin
            send_byte(stim[i]);
            if (i == 7) check("add_w0", {bus.op_valid_o, bus.op_data_o, bus.op_code_o, bus.op_first_o, bus.op_last_o},
                              {1'b1, 32'd1, 2'd0, 1'b1, 1'b0});
            if (i == 11) check("add_w1", {bus.op_valid_o, bus.op_data_o, bus.op_code_o, bus.op_first_o, bus.op_last_o},
                               {1'b1, 32'd2, 2'd0, 1'b0, 1'b1});
        end
        check("add_cycles", ($time - t0) / 10, 12);
        drain_compare("add");

        // mul packet under operand backpressure
        mode = 2;
        stim = '{8'h88, 8'h00, 8'h10, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
                 8'h04, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        model();
        fork
            send_stream(0);
            begin
                e = 0;
                while (!bus.op_valid_o && e < 100) begin @(negedge clk_i); e++; end
                held = bus.op_data_o;
                check("bp_first_word", held, 32'd3);
                repeat (10) @(negedge clk_i);
                check("bp_stable", bus.op_data_o, held);
                check("bp_ready_low", {bus.op_valid_o, bus.ready_o}, 2'b10);
                mode = 0;
            end
        join
        drain_compare("backpressure");

        // bad opcode drained, following echo intact
        stim = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB, 8'hEC, 8'h00, 8'h05, 8'h00, 8'h77};
        model();
        send_stream(0);
        drain_compare("bad_opcode");

        // bad lengths: misaligned payload, then len=2, then an echo
        stim = '{8'hAD, 8'h00, 8'h0A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                 8'h89, 8'h00, 8'h02, 8'h00, 8'hEC, 8'h00, 8'h05, 8'h00, 8'h99};
        model();
        send_stream(1);
        drain_compare("bad_length");

        // timeout inside an echo packet
        stim = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h41};
        for (int i = 0; i < stim.size(); i++) send_byte(stim[i]);
        e = 0;
        while (e < 150) begin
            @(posedge clk_i); #1;
            e++;
            if (bus.err_o) break;
        end
        check("timeout_cycles", e, 100);
        check("timeout_code", {bus.err_o, bus.err_code_o}, {1'b1, 2'd3});
        repeat (2) @(negedge clk_i);
        clear_q();
        @(posedge clk_i); #1;
        stim = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
        model();
        send_stream(0);
        drain_compare("after_timeout");

        // reset in the middle of the second operand
        stim = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
        send_stream(0);
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        check_outputs_zero("mid_reset");
        reset_i = 1'b0;
        clear_q();
        @(negedge clk_i);
        check("ready_after_mid_reset", bus.ready_o, 1);
        @(posedge clk_i); #1;
        stim = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                 8'h88, 8'h77, 8'h66, 8'h55};
        model();
        send_stream(0);
        drain_compare("after_reset");

        // randomized packet mix with random readies and input gaps
        mode = 1;
        for (int p = 0; p < 30; p++) gen_pkt();
        model();
        send_stream(2);
        mode = 0;
        drain_compare("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
